// File: rtl/dmem_responder_if.sv
// Core data-memory port bundle: request side driven by the core, response side by the RAM.
// DMEM_BYTE_STROBE_EN adds the per-byte write strobe.
interface dmem_responder_if;
    logic        mem_data_r_en;
    logic [31:0] mem_data_r_addr;
    logic [31:0] mem_data_r_data;
    logic        mem_data_w_en;
    logic [31:0] mem_data_w_addr;
    logic [31:0] mem_data_w_data;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  mem_data_w_strb;
`endif
    logic        rd_valid;
    logic        busy;
    logic        err;

    modport master (
        output mem_data_r_en, mem_data_r_addr,
        output mem_data_w_en, mem_data_w_addr, mem_data_w_data,
`ifdef DMEM_BYTE_STROBE_EN
        output mem_data_w_strb,
`endif
        input  mem_data_r_data, rd_valid, busy, err
    );

    modport slave (
        input  mem_data_r_en, mem_data_r_addr,
        input  mem_data_w_en, mem_data_w_addr, mem_data_w_data,
`ifdef DMEM_BYTE_STROBE_EN
        input  mem_data_w_strb,
`endif
        output mem_data_r_data, rd_valid, busy, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM responding to the core data port with fixed read latency.
// Optional byte-lane write strobes under DMEM_BYTE_STROBE_EN.
module dmem_responder #(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_enable,
    dmem_responder_if.slave  dmem
);
    localparam int         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           rd_buf;
    logic [ADDR_WIDTH-1:0] r_idx, w_idx;
    logic                  r_addr_ok, w_addr_ok;
    logic                  r_ok, w_ok, bad_access, run;
    state_t                state;
    logic [1:0]            cnt;
    logic                  pend;

    always_comb begin
        r_idx      = dmem.mem_data_r_addr[ADDR_WIDTH+1:2];
        w_idx      = dmem.mem_data_w_addr[ADDR_WIDTH+1:2];
        r_addr_ok  = (dmem.mem_data_r_addr[1:0] == 2'b00) &&
                     (dmem.mem_data_r_addr[31:ADDR_WIDTH+2] == '0);
        w_addr_ok  = (dmem.mem_data_w_addr[1:0] == 2'b00) &&
                     (dmem.mem_data_w_addr[31:ADDR_WIDTH+2] == '0);
        r_ok       = dmem.mem_data_r_en && r_addr_ok;
        w_ok       = dmem.mem_data_w_en && w_addr_ok;
        bad_access = (dmem.mem_data_r_en && !r_addr_ok) ||
                     (dmem.mem_data_w_en && !w_addr_ok);
        run        = clk_enable && !rst;
    end

    // Read data is captured at the request edge, so a same-edge write is not seen.
    always_ff @(posedge clk) begin
        if (run) begin
            if (w_ok) begin
`ifdef DMEM_BYTE_STROBE_EN
                for (int unsigned i = 0; i < 4; i++) begin
                    if (dmem.mem_data_w_strb[i])
                        mem[w_idx][8*i +: 8] <= dmem.mem_data_w_data[8*i +: 8];
                end
`else
                mem[w_idx] <= dmem.mem_data_w_data;
`endif
            end
            if (r_ok)
                rd_buf <= mem[r_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= ST_IDLE;
            cnt                  <= '0;
            pend                 <= 1'b0;
            dmem.mem_data_r_data <= '0;
            dmem.rd_valid        <= 1'b0;
            dmem.busy            <= 1'b0;
            dmem.err             <= 1'b0;
        end else if (clk_enable) begin
            dmem.rd_valid <= 1'b0;
            dmem.err      <= bad_access;
            case (state)
                ST_IDLE: begin
                    // Single-cycle latency: the previous load retires while a new one launches.
                    if (pend) begin
                        dmem.mem_data_r_data <= rd_buf;
                        dmem.rd_valid        <= 1'b1;
                        pend                 <= 1'b0;
                    end
                    if (r_ok) begin
                        cnt <= CNT_INIT;
                        if (READ_LATENCY == 1) begin
                            pend <= 1'b1;
                        end else begin
                            state     <= ST_WAIT;
                            dmem.busy <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_ok) begin
                        cnt <= CNT_INIT;
                    end else if (cnt == 2'd0) begin
                        dmem.mem_data_r_data <= rd_buf;
                        dmem.rd_valid        <= 1'b1;
                        dmem.busy            <= 1'b0;
                        state                <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (READ_LATENCY 1..3) share stimulus and are
// compared each cycle against a transaction-level model, plus directed literal checks.
module tb_dmem_responder;
    localparam int AW    = 10;
    localparam int DEPTH = 2 ** AW;

    logic        clk = 1'b0;
    logic        rst, ce;
    logic        r_en, w_en;
    logic [31:0] r_addr, w_addr, w_data;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  strb;
`endif

    logic [3:1][31:0] rdata;
    logic [3:1]       rdv, bsy, er;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_responder_if ifs[1:3] ();

    for (genvar k = 1; k <= 3; k++) begin : g_dut
        assign ifs[k].mem_data_r_en   = r_en;
        assign ifs[k].mem_data_r_addr = r_addr;
        assign ifs[k].mem_data_w_en   = w_en;
        assign ifs[k].mem_data_w_addr = w_addr;
        assign ifs[k].mem_data_w_data = w_data;
`ifdef DMEM_BYTE_STROBE_EN
        assign ifs[k].mem_data_w_strb = strb;
`endif
        assign rdata[k] = ifs[k].mem_data_r_data;
        assign rdv[k]   = ifs[k].rd_valid;
        assign bsy[k]   = ifs[k].busy;
        assign er[k]    = ifs[k].err;

        dmem_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(k)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .clk_enable (ce),
            .dmem       (ifs[k])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mram [DEPTH];
    longint      ecnt = 0;
    bit          m_pend [1:3];
    longint      m_due  [1:3];
    logic [31:0] m_pdat [1:3];
    logic [31:0] m_rdat [1:3];
    bit          m_rdv  [1:3];
    bit          m_busy [1:3];
    bit          m_err;
    bit          chk_on = 0;

    function automatic bit addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> (AW + 2)) == 0);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & (DEPTH - 1));
    endfunction

    task automatic model_step();
        bit          rok, wok;
        logic [31:0] rword;
        logic [3:0]  st;
        if (rst) begin
            for (int k = 1; k <= 3; k++) begin
                m_pend[k] = 0; m_rdat[k] = '0; m_rdv[k] = 0; m_busy[k] = 0;
            end
            m_err = 0;
        end else if (ce) begin
            ecnt++;
            rok   = r_en && addr_ok(r_addr);
            wok   = w_en && addr_ok(w_addr);
            m_err = (r_en && !addr_ok(r_addr)) || (w_en && !addr_ok(w_addr));
            rword = mram[widx(r_addr)];
            for (int k = 1; k <= 3; k++) begin
                m_rdv[k] = 0;
                if (rok && k > 1) m_pend[k] = 0;
                if (m_pend[k] && m_due[k] == ecnt) begin
                    m_rdat[k] = m_pdat[k];
                    m_rdv[k]  = 1;
                    m_pend[k] = 0;
                end
                if (rok) begin
                    m_pend[k] = 1;
                    m_due[k]  = ecnt + longint'(k);
                    m_pdat[k] = rword;
                end
                m_busy[k] = (k > 1) && m_pend[k];
            end
`ifdef DMEM_BYTE_STROBE_EN
            st = strb;
`else
            st = 4'hF;
`endif
            if (wok)
                for (int b = 0; b < 4; b++)
                    if (st[b]) mram[widx(w_addr)][8*b +: 8] = w_data[8*b +: 8];
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        if (chk_on) begin
            for (int k = 1; k <= 3; k++) begin
                check($sformatf("r_data[L%0d]", k), rdata[k], m_rdat[k]);
                check($sformatf("rd_valid[L%0d]", k), 32'(rdv[k]), 32'(m_rdv[k]));
                check($sformatf("busy[L%0d]", k), 32'(bsy[k]), 32'(m_busy[k]));
                check($sformatf("err[L%0d]", k), 32'(er[k]), 32'(m_err));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit re, input logic [31:0] ra, input bit we,
                       input logic [31:0] wa, input logic [31:0] wd);
        r_en = re; r_addr = ra; w_en = we; w_addr = wa; w_data = wd;
        @(negedge clk);
        r_en = 0; w_en = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned sel = $urandom_range(0, 9);
        logic [31:0] base = 32'($urandom_range(0, 15)) << 2;
        case (sel)
            0:       return base | 32'($urandom_range(1, 3));
            1:       return base | (32'h1 << (AW + 2));
            2:       return base | 32'h8000_0000;
            default: return base;
        endcase
    endfunction

    logic [31:0] w0;
    int          nrdv;

    initial begin
        rst = 1; ce = 1; r_en = 0; w_en = 0; r_addr = '0; w_addr = '0; w_data = '0;
`ifdef DMEM_BYTE_STROBE_EN
        strb = 4'hF;
`endif
        @(negedge clk); chk_on = 1;
        @(negedge clk);
        for (int k = 1; k <= 3; k++) check("reset r_data", rdata[k], 32'h0);
        check("reset busy", 32'(bsy), 32'h0);
        rst = 0;

        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 32'(i * 4), $urandom);
        w0 = mram[0];

        // 1: basic latency per instance
        cyc(0, 0, 1, 32'h10, 32'hDEADBEEF);
        cyc(1, 32'h10, 0, 0, 0);
        @(negedge clk);
        check("T1 L1 rd_valid", 32'(rdv[1]), 32'h1);
        check("T1 L1 data", rdata[1], 32'hDEADBEEF);
        check("T1 L3 busy", 32'(bsy[3]), 32'h1);
        @(negedge clk);
        check("T1 L2 data", rdata[2], 32'hDEADBEEF);
        @(negedge clk);
        check("T1 L3 rd_valid", 32'(rdv[3]), 32'h1);
        check("T1 L3 data", rdata[3], 32'hDEADBEEF);
        idle(2);

        // 2: clock-enable stall during the wait
        cyc(1, 32'h10, 1, 32'h10, 32'h0BAD0BAD);
        @(negedge clk);
        ce = 0; idle(4); ce = 1;
        @(negedge clk);
        check("T2 L3 still busy", 32'(bsy[3]), 32'h1);
        check("T2 L3 no rd_valid yet", 32'(rdv[3]), 32'h0);
        @(negedge clk);
        check("T2 L3 rd_valid", 32'(rdv[3]), 32'h1);
        check("T2 L3 data", rdata[3], 32'hDEADBEEF);
        idle(2);

        // 3: same-edge read/write returns old data
        cyc(0, 0, 1, 32'h20, 32'hAAAA5555);
        cyc(1, 32'h20, 1, 32'h20, 32'h12345678);
        idle(4);
        for (int k = 1; k <= 3; k++) check("T3 old value", rdata[k], 32'hAAAA5555);
        cyc(1, 32'h20, 0, 0, 0);
        idle(4);
        for (int k = 1; k <= 3; k++) check("T3 new value", rdata[k], 32'h12345678);

        // 4: rejected accesses
        cyc(1, 32'h2, 0, 0, 0);
        check("T4 err misaligned", 32'(er[1]), 32'h1);
        @(negedge clk);
        check("T4 err one pulse", 32'(er[1]), 32'h0);
        cyc(0, 0, 1, 32'h1 << (AW + 2), 32'hFFFF_FFFF);
        check("T4 err out of range", 32'(er[2]), 32'h1);
        cyc(1, 32'h3, 1, 32'h8000_0000, 32'h0);
        check("T4 err both bad", 32'(er[3]), 32'h1);
        @(negedge clk);
        check("T4 err both single", 32'(er[3]), 32'h0);
        for (int k = 1; k <= 3; k++) check("T4 r_data kept", rdata[k], 32'h12345678);
        cyc(1, 32'h0, 0, 0, 0);
        idle(4);
        check("T4 word0 unchanged", rdata[1], w0);

        // 5: superseded read and reset abort
        cyc(0, 0, 1, 32'h14, 32'hCAFE0014);
        cyc(1, 32'h10, 0, 0, 0);
        cyc(1, 32'h14, 0, 0, 0);
        nrdv = 0;
        for (int i = 0; i < 5; i++) begin
            if (rdv[2]) nrdv++;
            @(negedge clk);
        end
        check("T5 L2 one rd_valid", 32'(nrdv), 32'h1);
        check("T5 L2 data", rdata[2], 32'hCAFE0014);
        cyc(1, 32'h10, 0, 0, 0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        nrdv = 0;
        for (int i = 0; i < 5; i++) begin
            nrdv += int'(rdv[1]) + int'(rdv[2]) + int'(rdv[3]);
            @(negedge clk);
        end
        check("T5 reset abort rd_valid", 32'(nrdv), 32'h0);
        for (int k = 1; k <= 3; k++) check("T5 reset r_data", rdata[k], 32'h0);

`ifdef DMEM_BYTE_STROBE_EN
        // 6: byte strobes
        cyc(0, 0, 1, 32'h30, 32'hDEADBEEF);
        strb = 4'b0101;
        cyc(0, 0, 1, 32'h30, 32'h11223344);
        strb = 4'hF;
        cyc(1, 32'h30, 0, 0, 0);
        idle(4);
        check("T6 strobe merge", rdata[1], 32'hDE22BE44);
        strb = 4'b0000;
        cyc(0, 0, 1, 32'h30, 32'h55555555);
        check("T6 zero strobe no err", 32'(er[1]), 32'h0);
        strb = 4'hF;
        cyc(1, 32'h30, 0, 0, 0);
        idle(4);
        check("T6 zero strobe unchanged", rdata[3], 32'hDE22BE44);
`endif

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            ce     = ($urandom_range(0, 9) != 0);
            rst    = ($urandom_range(0, 99) == 0);
            r_en   = ($urandom_range(0, 2) == 0);
            r_addr = rand_addr();
            w_en   = ($urandom_range(0, 2) == 0);
            w_addr = rand_addr();
            w_data = $urandom;
`ifdef DMEM_BYTE_STROBE_EN
            strb   = 4'($urandom);
`endif
            @(negedge clk);
        end
        rst = 0; ce = 1; r_en = 0; w_en = 0;
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
